serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full_adder reused LSB-first across WIDTH clocks.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             cf;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] sum_nxt;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (cf),
    .s  (fa_s),
    .co (fa_co)
  );

  // Subtraction is a + ~b + 1; carry out of 1 then means no borrow.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : c_in;
`else
  assign b_load = b;
  assign c_load = c_in;
`endif

  // New sum bit enters at the MSB; the whole register shifts right.
  assign sum_nxt = WIDTH'({fa_s, sum_sr} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b_load;
            cf       <= c_load;
            sum_sr   <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          cf     <= fa_co;
          // Counter holds on the last bit so it never wraps naturally.
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            sum       <= sum_nxt;
            carry     <= fa_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random stream.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vci;
    logic [W-1:0] esum;
    logic         ecarry;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    logic [W:0] r;
    if (s) r = {(x >= y), W'(x - y)};
    else   r = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
    return r;
  endfunction

  // One full transaction with latency, stability and handshake checks.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tci,
                       input logic ts, input logic [W-1:0] es, input logic ec, input int hold);
    int   lat;
    logic early;
    lat = 0;
    while (!in_ready && lat < 50) begin step(); lat++; end
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    a = ta; b = tb2; c_in = tci; sub = ts; in_valid = 1'b1; out_ready = (hold == 0);
    step();
    in_valid = 1'b0; a = ~ta; b = ~tb2; c_in = ~tci;
    check("busy_in_shift", 32'(busy), 32'd1);
    lat = 1; early = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) early = 1'b1;
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("in_ready_low_in_shift", 32'(early), 32'd0);
    check("sum", 32'(sum), 32'(es));
    check("carry", 32'(carry), 32'(ec));
    check("in_ready_low_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'h99; b = 8'h66;
      step();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(es));
      check("hold_carry", 32'(carry), 32'(ec));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  vec_t         vecs[5];
  logic [W:0]   q[$];
  logic [W:0]   e;
  int           issued, got, cyc, last_hs, lat;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vci, 1'b0, vecs[i].esum, vecs[i].ecarry, 0);

    // Backpressure: result held for 5 cycles, in_valid pulses ignored.
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 5);

    // out_ready and in_valid together in DONE: new operands wait for IDLE.
    a = 8'hEE; b = 8'h11; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check("seq_latency", 32'(lat), 32'(W + 1));
    check("seq_sum", 32'(sum), 32'hFF);
    a = 8'h33; b = 8'h44; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("seq_not_accepted_out_valid", 32'(out_valid), 32'd0);
    check("seq_not_accepted_in_ready", 32'(in_ready), 32'd1);
    step();
    check("seq_accepted_in_ready", 32'(in_ready), 32'd0);
    check("seq_accepted_busy", 32'(busy), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check("seq2_latency", 32'(lat), 32'(W + 1));
    check("seq2_sum", 32'(sum), 32'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during the 3rd SHIFT cycle discards the partial result.
    a = 8'hF0; b = 8'h0F; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 0);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 0);
    sub = 1'b0;
`endif

    // Random back-to-back stream with out_ready tied high.
    out_ready = 1'b1; in_valid = 1'b1;
    issued = 0; got = 0; cyc = 0; last_hs = -1;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    while ((issued < 200 || got < 200) && cyc < 5000) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rand_sum", 32'(sum), 32'(e[W-1:0]));
          check("rand_carry", 32'(carry), 32'(e[W]));
        end else begin
          check("rand_unexpected_result", 32'd1, 32'd0);
        end
        got++;
      end
      if (in_ready && in_valid) begin
        q.push_back(model(a, b, c_in, sub));
        if (last_hs >= 0) check("rand_spacing", 32'(cyc - last_hs), 32'(W + 2));
        last_hs = cyc;
        issued++;
      end
      step();
      cyc++;
      if (issued >= 200) in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
    end
    check("rand_results_received", 32'(got), 32'd200);
    check("rand_issued", 32'(issued), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
